oam_dma: RTL and testbench
==========================

Name: oam_dma

Overview:
- OAM DMA engine; consumes the DMA page register exported by the PPU (`dmaAdress`).
- On a new page request it copies NUM_BYTES bytes from the source page to OAM at 0xFE00.
- Masters the system read bus and the OAM write port. Asserts `busy` so the MMU can lock the CPU to HRAM for the duration.

Parameters:
- NUM_BYTES, 160, number of bytes per transfer (OAM size).
- RD_LAT, 2, cycles from registered `A_src` to valid `Di_src` (minimum 1).
- OAM_BASE, 16'hFE00, destination base address.

Ports:
- clock  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- dma_page  input  8  PPU DMA register; 8'h00 = idle, held nonzero while the CPU write is active
- A_src  output  16  source read address
- rd_src  output  1  source read strobe
- Di_src  input  8  source read data
- A_oam  output  16  OAM write address
- Do_oam  output  8  OAM write data
- wr_oam  output  1  OAM write strobe, one cycle per byte
- busy  output  1  transfer in progress
- done  output  1  one-cycle pulse after the last OAM write

Behaviour:
- Reset (async, reset_n=0):
  - All outputs 0; state IDLE; byte index 0; page_q 0.
  - Takes effect mid-transfer: the transfer is abandoned and no further `wr_oam` is issued.
- Start detection:
  - page_q registers `dma_page` every cycle.
  - start = (dma_page != 0) && (page_q == 0).
  - A held nonzero value does not retrigger.
  - Page 0x00 cannot be requested; this is a system-level decision.
- Source page mapping:
  - src_page = page − 8'h20 if page ≥ 8'hE0 (echo RAM), else page.
  - The page is latched at start.
- States: IDLE, ADDR, WAIT, WRITE.
  - IDLE: `busy`=0. On start: latch page, idx←0, go to ADDR.
  - ADDR (1 cycle):
    - `A_src`←{src_page, idx}, `rd_src`←1, wait counter←1.
    - `busy`=1 from the first ADDR cycle.
    - If RD_LAT=1, go to WRITE; else go to WAIT.
  - WAIT: increment the counter. When counter == RD_LAT−1, go to WRITE.
  - WRITE (1 cycle):
    - Capture `Di_src` into `Do_oam`; `A_oam`←OAM_BASE + idx; `wr_oam`←1 for exactly this cycle; `rd_src`←0.
    - If idx == NUM_BYTES−1: go to IDLE, `done`←1 for one cycle, `busy`←0.
    - Else: idx←idx+1, go to ADDR.
- Timing:
  - Each byte takes RD_LAT+1 cycles.
  - Full transfer = NUM_BYTES·(RD_LAT+1) cycles: 480 with defaults.
  - First `A_src` appears the cycle after the start edge is registered.
- Widths:
  - idx is 8 bits; the `A_src` low byte = idx.
  - NUM_BYTES must be ≤ 256; the `A_oam` addition is 16 bits, no wrap.
- Restart while busy: a new start edge during any non-IDLE state aborts the current copy.
  - Drop `wr_oam` (unless it coincides with the current WRITE cycle, in which case that write completes).
  - Latch the new page, idx←0, enter ADDR next cycle.
  - No `done` for the aborted transfer.
- Simultaneous events:
  - A start edge on the same cycle as the final WRITE: that write completes, `done` is suppressed, the new transfer begins.
- Output hold:
  - `A_oam` and `Do_oam` hold their last values when `wr_oam`=0.
  - `A_src` holds its value after `rd_src` drops.

Decomposition:
- Shared package ppu_pkg:
  - OAM_BASE, OAM_SIZE (160), ECHO_START (8'hE0), ECHO_OFFSET (8'h20).
  - DMA state enum {IDLE, ADDR, WAIT, WRITE}.
- One natural sub-module: dma_start_detect (page_q register and the zero-to-nonzero edge detector).
- Everything else stays in oam_dma.

Test Plan:
- Basic copy:
  - Stimulus: preload 0xC000–0xC09F with data = low byte of address XOR 0x5A; pulse dma_page=0xC0 for 3 cycles then 0x00.
  - Required response: exactly 160 `wr_oam` pulses at 0xFE00..0xFE9F with matching data; `done` pulses at cycle 480 after start; `busy` high throughout.
- Held request:
  - Stimulus: hold dma_page=0x80 for 600 cycles.
  - Required response: exactly one transfer (160 writes, one `done`).
- Echo mapping:
  - Stimulus: dma_page=0xE1.
  - Required response: `A_src` sequence 0xC100..0xC19F.
- Restart:
  - Stimulus: start with 0xC0; at write #50 drop dma_page to 0, then issue 0xD0.
  - Required response: writes 0–49 from 0xC0xx, then a fresh 160 writes from 0xD000 starting at 0xFE00; a single `done`.
- Reset mid-transfer:
  - Stimulus: assert reset_n=0 asynchronously at byte 20 (between clock edges).
  - Required response: all outputs 0 immediately; no writes after release until a new start edge.
- RD_LAT=1 build:
  - Required response: 2 cycles/byte, `done` 320 cycles after start, data still correct.

Source files
------------

// File: rtl/ppu_pkg.sv
`default_nettype none
// Shared PPU-side constants and the OAM DMA state encoding.
// Rev 1.0
package ppu_pkg;

  localparam logic [15:0] OAM_BASE    = 16'hFE00;
  localparam int          OAM_SIZE    = 160;
  localparam logic [7:0]  ECHO_START  = 8'hE0;
  localparam logic [7:0]  ECHO_OFFSET = 8'h20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } dma_state_e;

  // Pages in the echo region alias work RAM 0x20 pages lower.
  function automatic logic [7:0] map_src_page(input logic [7:0] page);
    return (page >= ECHO_START) ? (page - ECHO_OFFSET) : page;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dma_start_detect.sv
`default_nettype none
// Registers the PPU DMA page every cycle and flags a zero-to-nonzero transition.
// Rev 1.0
module dma_start_detect (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] dma_page,
  output logic       start
);

  logic [7:0] page_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) page_q <= 8'h00;
    else          page_q <= dma_page;
  end

  assign start = (dma_page != 8'h00) && (page_q == 8'h00);

endmodule
`default_nettype wire

// File: rtl/oam_dma.sv
`default_nettype none
// OAM DMA engine: copies NUM_BYTES bytes from a source page into OAM.
// Rev 1.0
module oam_dma #(
  parameter int          NUM_BYTES = ppu_pkg::OAM_SIZE,
  parameter int          RD_LAT    = 2,
  parameter logic [15:0] OAM_BASE  = ppu_pkg::OAM_BASE
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  dma_page,
  output logic [15:0] A_src,
  output logic        rd_src,
  input  logic [7:0]  Di_src,
  output logic [15:0] A_oam,
  output logic [7:0]  Do_oam,
  output logic        wr_oam,
  output logic        busy,
  output logic        done
);

  import ppu_pkg::*;

  dma_state_e state, state_next;
  logic       start;
  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] cnt;
  logic       last;

  dma_start_detect u_start_detect (
    .clock    (clock),
    .reset_n  (reset_n),
    .dma_page (dma_page),
    .start    (start)
  );

  assign last = (idx == 8'(NUM_BYTES - 1));
  assign busy = (state != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // A new start edge pre-empts whatever the engine is doing.
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = ADDR;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        ADDR:    state_next = (RD_LAT == 1) ? WRITE : WAIT;
        WAIT:    if (cnt == 8'(RD_LAT - 1)) state_next = WRITE;
        WRITE:   state_next = last ? IDLE : ADDR;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      page   <= 8'h00;
      idx    <= 8'h00;
      cnt    <= 8'h00;
      A_src  <= 16'h0000;
      rd_src <= 1'b0;
      A_oam  <= 16'h0000;
      Do_oam <= 8'h00;
      wr_oam <= 1'b0;
      done   <= 1'b0;
    end else begin
      wr_oam <= 1'b0;
      done   <= 1'b0;
      // A write already in flight completes even when a restart lands on it.
      if (state == WRITE) begin
        Do_oam <= Di_src;
        A_oam  <= OAM_BASE + {8'h00, idx};
        wr_oam <= 1'b1;
        rd_src <= 1'b0;
        if (last && !start) done <= 1'b1;
      end
      if (start) begin
        page <= map_src_page(dma_page);
        idx  <= 8'h00;
      end else begin
        case (state)
          ADDR: begin
            A_src  <= {page, idx};
            rd_src <= 1'b1;
            cnt    <= 8'd1;
          end
          WAIT:    cnt <= cnt + 8'd1;
          WRITE:   if (!last) idx <= idx + 8'd1;
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_oam_dma.sv
`default_nettype none
// Randomized self-checking bench for oam_dma (RD_LAT=2 and RD_LAT=1 instances).
// Rev 1.0
module tb_oam_dma;

  localparam int NB = 160;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] dma_page [2];
  wire [15:0] A_src    [2];
  wire        rd_src   [2];
  wire [7:0]  Di_src   [2];
  wire [15:0] A_oam    [2];
  wire [7:0]  Do_oam   [2];
  wire        wr_oam   [2];
  wire        busy     [2];
  wire        done     [2];

  logic [7:0]  mem [65536];
  logic [7:0]  rd_pipe;
  int          cyc = 0;
  logic [39:0] wq [2][$];
  int          done_cnt [2];
  int          done_cyc [2];
  int          busy_cnt [2];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Source memory: two-cycle path (one register after the DUT's address register) and a combinational one.
  always @(posedge clock) rd_pipe <= mem[A_src[0]];
  assign Di_src[0] = rd_pipe;
  assign Di_src[1] = mem[A_src[1]];

  oam_dma #(.NUM_BYTES(NB), .RD_LAT(2)) u_dut_lat2 (
    .clock(clock), .reset_n(reset_n), .dma_page(dma_page[0]),
    .A_src(A_src[0]), .rd_src(rd_src[0]), .Di_src(Di_src[0]),
    .A_oam(A_oam[0]), .Do_oam(Do_oam[0]), .wr_oam(wr_oam[0]),
    .busy(busy[0]), .done(done[0])
  );

  oam_dma #(.NUM_BYTES(NB), .RD_LAT(1)) u_dut_lat1 (
    .clock(clock), .reset_n(reset_n), .dma_page(dma_page[1]),
    .A_src(A_src[1]), .rd_src(rd_src[1]), .Di_src(Di_src[1]),
    .A_oam(A_oam[1]), .Do_oam(Do_oam[1]), .wr_oam(wr_oam[1]),
    .busy(busy[1]), .done(done[1])
  );

  for (genvar g = 0; g < 2; g++) begin : g_mon
    always @(negedge clock) begin
      if (wr_oam[g]) wq[g].push_back({A_src[g], A_oam[g], Do_oam[g]});
      if (done[g]) begin
        done_cnt[g] = done_cnt[g] + 1;
        done_cyc[g] = cyc;
      end
      if (busy[g]) busy_cnt[g] = busy_cnt[g] + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  // Expected write i of a copy from page: source address, OAM address, data.
  function automatic logic [39:0] exp_entry(input int page, input int i);
    int src;
    int a;
    src = (page >= 224) ? page - 32 : page;
    a   = src * 256 + i;
    return {a[15:0], 16'(32'hFE00 + i), mem[a]};
  endfunction

  function automatic logic [63:0] out_vec(input int u);
    return {20'h0, A_src[u], rd_src[u], A_oam[u], Do_oam[u], wr_oam[u], busy[u], done[u]};
  endfunction

  task automatic check_seq(input int u, input string tag, input int pa, input int na,
                           input int pb, input int nb);
    chk({tag, "_count"}, wq[u].size(), na + nb);
    for (int i = 0; i < na + nb && i < wq[u].size(); i++)
      chk(tag, wq[u][i], (i < na) ? exp_entry(pa, i) : exp_entry(pb, i - na));
  endtask

  task automatic wait_done(input int u, input int prev, input int budget);
    int k;
    k = 0;
    while (done_cnt[u] == prev && k < budget) begin
      tick(1);
      k++;
    end
    chk("done_timeout", (done_cnt[u] == prev), 0);
  endtask

  task automatic begin_test(input int u, output int prev);
    wq[u].delete();
    busy_cnt[u] = 0;
    prev = done_cnt[u];
  endtask

  initial begin
    int prev, t0, p, p2, k, nq, nd;
    logic [7:0] echo_pages [2];

    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int a = 'hC000; a < 'hC0A0; a++) mem[a] = 8'(a) ^ 8'h5A;
    dma_page[0] = 8'h00;
    dma_page[1] = 8'h00;

    tick(3);
    chk("reset_out_lat2", out_vec(0), 0);
    chk("reset_out_lat1", out_vec(1), 0);
    reset_n = 1'b1;
    tick(2);

    // Basic copy from 0xC0, request pulsed for three cycles.
    begin_test(0, prev);
    dma_page[0] = 8'hC0;
    t0 = cyc;
    tick(3);
    dma_page[0] = 8'h00;
    wait_done(0, prev, 2000);
    tick(5);
    check_seq(0, "basic", 'hC0, NB, 0, 0);
    chk("basic_done_n", done_cnt[0] - prev, 1);
    chk("basic_latency", done_cyc[0] - t0 - 1, NB * 3);
    chk("basic_busy_cycles", busy_cnt[0], NB * 3);

    // Held nonzero request must not retrigger.
    begin_test(0, prev);
    p = $urandom_range(1, 223);
    dma_page[0] = 8'(p);
    tick(600);
    dma_page[0] = 8'h00;
    tick(50);
    check_seq(0, "held", p, NB, 0, 0);
    chk("held_done_n", done_cnt[0] - prev, 1);

    // Echo-region pages alias 0x20 pages lower.
    echo_pages[0] = 8'hE1;
    echo_pages[1] = 8'($urandom_range(224, 255));
    for (int e = 0; e < 2; e++) begin
      begin_test(0, prev);
      dma_page[0] = echo_pages[e];
      tick(3);
      dma_page[0] = 8'h00;
      wait_done(0, prev, 2000);
      tick(5);
      check_seq(0, "echo", echo_pages[e], NB, 0, 0);
    end

    // Restart part-way through a copy.
    begin_test(0, prev);
    k  = $urandom_range(10, 150);
    p2 = $urandom_range(1, 255);
    dma_page[0] = 8'hC0;
    tick(3);
    dma_page[0] = 8'h00;
    nq = 0;
    while (wq[0].size() < k && nq < 2000) begin
      tick(1);
      nq++;
    end
    chk("restart_reach_timeout", (wq[0].size() < k), 0);
    tick(1);
    dma_page[0] = 8'(p2);
    tick(3);
    dma_page[0] = 8'h00;
    wait_done(0, prev, 2000);
    tick(20);
    check_seq(0, "restart", 'hC0, k, p2, NB);
    chk("restart_done_n", done_cnt[0] - prev, 1);

    // Asynchronous reset between clock edges mid-transfer.
    begin_test(0, prev);
    p = $urandom_range(1, 255);
    dma_page[0] = 8'(p);
    nq = 0;
    while (wq[0].size() < 20 && nq < 2000) begin
      tick(1);
      nq++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("rstmid_out", out_vec(0), 0);
    dma_page[0] = 8'h00;
    nq = wq[0].size();
    nd = done_cnt[0];
    check_seq(0, "rstmid_pre", p, 20, 0, 0);
    tick(3);
    reset_n = 1'b1;
    tick(600);
    chk("rstmid_no_writes", wq[0].size(), nq);
    chk("rstmid_no_done", done_cnt[0], nd);

    // Single-cycle read latency instance.
    begin_test(1, prev);
    p = $urandom_range(1, 255);
    dma_page[1] = 8'(p);
    t0 = cyc;
    tick(3);
    dma_page[1] = 8'h00;
    wait_done(1, prev, 2000);
    tick(5);
    check_seq(1, "lat1", p, NB, 0, 0);
    chk("lat1_latency", done_cyc[1] - t0 - 1, NB * 2);
    chk("lat1_busy_cycles", busy_cnt[1], NB * 2);
    chk("lat1_done_n", done_cnt[1] - prev, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
